// File: rtl/raster_tx_retriever_pkg.sv
// Shared types for the raster transmit retriever.
// State encoding, default field widths and {row,col} packing.
package raster_tx_pkg;

    localparam int DEF_ROW_W  = 9;
    localparam int DEF_COL_W  = 9;
    localparam int DEF_DATA_W = 8;
    localparam int ADDR_W     = DEF_ROW_W + DEF_COL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_WAIT_TICK,
        S_ADVANCE,
        S_FINISH,
        S_CHKSUM
    } state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [DEF_ROW_W-1:0] row,
        input logic [DEF_COL_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/raster_tx_retriever_if.sv
// RAM read port and UART transmit handshake of the retriever.
// master = retriever side, slave = RAM/transmitter side.
interface raster_tx_retriever_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] tx_data;
    logic              tx_wen;
    logic              tx_tick;

    modport master (
        output address, tx_data, tx_wen,
        input  mem_q, tx_tick
    );

    modport slave (
        input  address, tx_data, tx_wen,
        output mem_q, tx_tick
    );
endinterface

// File: rtl/raster_tx_retriever_addr_counter.sv
// Row/column walker: load, raster step, last-address and range compare.
// Fields are stepped independently; column wraps to the start column.
module raster_addr_counter #(
    parameter int ROW_W = 9,
    parameter int COL_W = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   step,
    input  logic [ROW_W+COL_W-1:0] start_address,
    input  logic [ROW_W+COL_W-1:0] end_address,
    output logic [ROW_W+COL_W-1:0] address,
    output logic                   is_last,
    output logic                   range_bad
);
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] end_row;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] start_col;
    logic [COL_W-1:0] end_col;

    assign range_bad =
        (start_address[ROW_W+COL_W-1:COL_W] > end_address[ROW_W+COL_W-1:COL_W]) ||
        (start_address[COL_W-1:0] > end_address[COL_W-1:0]);

    assign is_last = (row == end_row) && (col == end_col);
    assign address = {row, col};

    // Capture region bounds at start, then walk columns within rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            start_col <= '0;
            end_row   <= '0;
            end_col   <= '0;
        end else if (load) begin
            start_col <= start_address[COL_W-1:0];
            end_row   <= end_address[ROW_W+COL_W-1:COL_W];
            end_col   <= end_address[COL_W-1:0];
            if (!range_bad) begin
                row <= start_address[ROW_W+COL_W-1:COL_W];
                col <= start_address[COL_W-1:0];
            end
        end else if (step) begin
            if (col == end_col) begin
                col <= start_col;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/raster_tx_retriever.sv
// Feeds bytes of a 2-D RAM region to the UART, one per transmit tick.
// Optional trailing checksum byte: RASTER_TX_RETRIEVER_CHECKSUM_EN.
module raster_tx_retriever
    import raster_tx_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int COL_W   = DEF_COL_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROW_W+COL_W-1:0] start_address,
    input  logic [ROW_W+COL_W-1:0] end_address,
    raster_tx_retriever_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   range_err
);
    state_t            state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_wen_q;
    logic              load;
    logic              step;
    logic              is_last;
    logic              range_bad;
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              chk_sent;
`endif

    assign load        = (state == S_IDLE) && start;
    assign step        = (state == S_ADVANCE);
    assign bus.tx_data = tx_data_q;
    assign bus.tx_wen  = tx_wen_q;

    raster_addr_counter #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .step          (step),
        .start_address (start_address),
        .end_address   (end_address),
        .address       (bus.address),
        .is_last       (is_last),
        .range_bad     (range_bad)
    );

    // Sequencer: read, send, wait for tick, advance; outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tx_data_q <= '0;
            tx_wen_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
            sum       <= '0;
            chk_sent  <= 1'b0;
`endif
        end else begin
            tx_wen_q <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        range_err <= range_bad;
                        cnt       <= '0;
                        busy      <= 1'b1;
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
                        sum       <= '0;
                        chk_sent  <= 1'b0;
`endif
                        if (range_bad) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt == 3'(MEM_LAT - 1)) begin
                        tx_data_q <= bus.mem_q;
                        tx_wen_q  <= 1'b1;
                        cnt       <= '0;
                        state     <= S_SEND;
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
                        sum       <= sum + bus.mem_q;
`endif
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (bus.tx_tick) begin
                        if (is_last) begin
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
                            if (!chk_sent) begin
                                state <= S_CHKSUM;
                            end else begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end
`else
                            state <= S_FINISH;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    cnt   <= '0;
                    state <= S_READ;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
                S_CHKSUM: begin
                    tx_data_q <= sum;
                    tx_wen_q  <= 1'b1;
                    chk_sent  <= 1'b1;
                    state     <= S_SEND;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_raster_tx_retriever.sv
// Directed bench for raster_tx_retriever with an expected-byte scoreboard.
// Honours RASTER_TX_RETRIEVER_CHECKSUM_EN for the trailing checksum byte.
module tb_raster_tx_retriever;
    import raster_tx_pkg::*;

`ifdef RASTER_TX_RETRIEVER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] start_address = '0;
    logic [17:0] end_address = '0;
    logic        busy;
    logic        done;
    logic        range_err;

    raster_tx_retriever_if #(.ADDR_W(18), .DATA_W(8)) bus ();

    raster_tx_retriever #(
        .ROW_W   (9),
        .COL_W   (9),
        .DATA_W  (8),
        .MEM_LAT (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_address (start_address),
        .end_address   (end_address),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .range_err     (range_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_wen_cyc = 0;
    int acc_cyc = 0;
    int tick_delay = 5;
    int tick_cnt = 0;
    logic [17:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [17:0] seen_addr[$];
    logic [7:0]  seen_data[$];

    function automatic logic [7:0] ram_byte(input logic [17:0] a);
        logic [17:0] t;
        case (a)
            18'd0:   return 8'hF0;
            18'd1:   return 8'h20;
            18'd2:   return 8'h05;
            default: begin
                t = a * 18'd3;
                return t[7:0] ^ a[16:9];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // one-cycle registered RAM behind the registered address
    initial begin
        bus.mem_q = '0;
        forever begin
            @(posedge clk);
            bus.mem_q <= ram_byte(bus.address);
        end
    end

    // transmitter: tick pulses tick_delay cycles after each wen
    initial begin
        bus.tx_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tick_cnt = 0;
                bus.tx_tick = 1'b0;
            end else if (bus.tx_wen) begin
                tick_cnt = tick_delay;
                bus.tx_tick = 1'b0;
            end else if (tick_cnt > 0) begin
                tick_cnt--;
                bus.tx_tick = (tick_cnt == 0);
            end else begin
                bus.tx_tick = 1'b0;
            end
        end
    end

    // compare process: every wen against the scoreboard, every done
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.tx_wen) begin
                wen_cnt++;
                if (wen_cnt == 1) first_wen_cyc = cyc;
                seen_addr.push_back(bus.address);
                seen_data.push_back(bus.tx_data);
                if (exp_addr_q.size() == 0) begin
                    check("extra_wen", 32'(wen_cnt), 32'(0));
                end else begin
                    check("wen_addr", 32'(bus.address), 32'(exp_addr_q.pop_front()));
                    check("wen_data", 32'(bus.tx_data), 32'(exp_data_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_all_sent", 32'(exp_addr_q.size()), 32'(0));
                check("busy_at_done", 32'(busy), 32'(1));
            end
        end
    end

    task automatic launch(input logic [17:0] sa, input logic [17:0] ea,
                          input bit bad);
        logic [7:0]  sum;
        logic [17:0] a;
        exp_addr_q.delete();
        exp_data_q.delete();
        seen_addr.delete();
        seen_data.delete();
        wen_cnt = 0;
        sum = '0;
        a = sa;
        if (!bad) begin
            for (int r = int'(sa[17:9]); r <= int'(ea[17:9]); r++) begin
                for (int c = int'(sa[8:0]); c <= int'(ea[8:0]); c++) begin
                    a = pack_addr(9'(r), 9'(c));
                    exp_addr_q.push_back(a);
                    exp_data_q.push_back(ram_byte(a));
                    sum = sum + ram_byte(a);
                end
            end
            if (CK == 1) begin
                exp_addr_q.push_back(a);
                exp_data_q.push_back(sum);
            end
        end
        @(negedge clk);
        start_address = sa;
        end_address = ea;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int d0;
        int n;
        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_address", 32'(bus.address), 32'(0));
        check("rst_tx_data", 32'(bus.tx_data), 32'(0));
        check("rst_tx_wen", 32'(bus.tx_wen), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_range_err", 32'(range_err), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // row 0, cols 0..2
        d0 = done_cnt;
        launch(18'd0, 18'd2, 1'b0);
        #1;
        check("busy_after_start", 32'(busy), 32'(1));
        wait_done(d0);
        check("t1_wen_count", 32'(wen_cnt), 32'(3 + CK));
        check("t1_done_count", 32'(done_cnt - d0), 32'(1));
        check("t1_first_wen_latency", 32'(first_wen_cyc + 1 - acc_cyc), 32'(3));
        check("t1_byte0_literal", 32'(seen_data[0]), 32'(8'hF0));
        check("t1_addr2_literal", 32'(seen_addr[2]), 32'(18'd2));
        if (CK == 1) check("t1_checksum_literal", 32'(seen_data[3]), 32'(8'h15));
        @(negedge clk);
        #1;
        check("t1_idle_busy", 32'(busy), 32'(0));

        // column wrap across rows 1..3
        d0 = done_cnt;
        launch(pack_addr(9'd1, 9'd510), pack_addr(9'd3, 9'd511), 1'b0);
        wait_done(d0);
        check("t2_wen_count", 32'(wen_cnt), 32'(6 + CK));
        check("t2_addr1_literal", 32'(seen_addr[1]), 32'(18'h003FF));
        check("t2_addr2_literal", 32'(seen_addr[2]), 32'(18'h005FE));
        check("t2_addr5_literal", 32'(seen_addr[5]), 32'(18'h007FF));

        // single address, start pulse while busy must be ignored
        d0 = done_cnt;
        tick_delay = 1;
        launch(pack_addr(9'd5, 9'd5), pack_addr(9'd5, 9'd5), 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (wen_cnt == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);
        repeat (10) @(negedge clk);
        #1;
        check("t3_wen_count", 32'(wen_cnt), 32'(1 + CK));
        check("t3_done_count", 32'(done_cnt - d0), 32'(1));
        tick_delay = 5;

        // inverted row range
        d0 = done_cnt;
        launch(pack_addr(9'd2, 9'd0), pack_addr(9'd1, 9'd9), 1'b1);
        #1;
        check("t4_done_now", 32'(done_cnt - d0), 32'(1));
        check("t4_done_cycle", 32'(done_cyc - acc_cyc), 32'(0));
        check("t4_range_err", 32'(range_err), 32'(1));
        repeat (4) @(negedge clk);
        #1;
        check("t4_wen_count", 32'(wen_cnt), 32'(0));
        check("t4_range_err_sticky", 32'(range_err), 32'(1));

        // reset during wait of the second byte, then full restart
        d0 = done_cnt;
        launch(pack_addr(9'd0, 9'd4), pack_addr(9'd0, 9'd7), 1'b0);
        #1;
        check("t5_range_err_cleared", 32'(range_err), 32'(0));
        n = 0;
        while (wen_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_wen_seen", 32'(wen_cnt), 32'(2));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_address", 32'(bus.address), 32'(0));
        check("t5_rst_tx_data", 32'(bus.tx_data), 32'(0));
        check("t5_rst_tx_wen", 32'(bus.tx_wen), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_done", 32'(done), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_done", 32'(done_cnt - d0), 32'(0));
        launch(pack_addr(9'd0, 9'd4), pack_addr(9'd0, 9'd7), 1'b0);
        wait_done(d0);
        check("t5_wen_count", 32'(wen_cnt), 32'(4 + CK));
        check("t5_first_addr", 32'(seen_addr[0]), 32'(18'd4));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
